// File: rtl/axi_hdr_pkg.sv
// Shared types and widths for the header-insert path (arbiter and insert engine).
package axi_hdr_pkg;

  localparam int DATA_WD      = 32;
  localparam int DATA_BYTE_WD = DATA_WD / 8;
  localparam int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD) + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HDR     = 2'd1,
    PAYLOAD = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first requester at or after ptr, searching upward with wrap.
// Latency: purely combinational, no state.
// Backpressure: none; the caller decides when a grant is taken.
module rr_arbiter #(
  parameter int NUM_SRC   = 4,
  parameter int SRC_ID_WD = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0]   req,
  input  logic [SRC_ID_WD-1:0] ptr,
  output logic [NUM_SRC-1:0]   grant,
  output logic [SRC_ID_WD-1:0] grant_idx,
  output logic                 any_req
);

  logic [SRC_ID_WD:0]   sum;
  logic [SRC_ID_WD-1:0] idx;
  logic                 found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_req   = |req;
    found     = 1'b0;
    sum       = '0;
    idx       = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      // ptr and k are both below NUM_SRC, so one conditional subtract wraps the sum
      sum = {1'b0, ptr} + (SRC_ID_WD+1)'(k);
      if (sum >= (SRC_ID_WD+1)'(NUM_SRC)) begin
        sum = sum - (SRC_ID_WD+1)'(NUM_SRC);
      end
      idx = sum[SRC_ID_WD-1:0];
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/axi_stream_header_arbiter.sv
// Shares one header-insert engine among NUM_SRC sources; grant held for header plus whole payload.
// Latency: one registered decision cycle in IDLE, then header/payload pass through combinationally.
// Backpressure: engine ready steered only to the owner; all other source readies held at 0.
module axi_stream_header_arbiter
  import axi_hdr_pkg::*;
#(
  parameter int DATA_WD      = axi_hdr_pkg::DATA_WD,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD) + 1,
  parameter int NUM_SRC      = 4,
  parameter int SRC_ID_WD    = $clog2(NUM_SRC)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_SRC-1:0]                s_valid_insert,
  input  logic [NUM_SRC*DATA_WD-1:0]        s_data_insert,
  input  logic [NUM_SRC*DATA_BYTE_WD-1:0]   s_keep_insert,
  output logic [NUM_SRC-1:0]                s_ready_insert,
  input  logic [NUM_SRC-1:0]                s_valid_in,
  input  logic [NUM_SRC*DATA_WD-1:0]        s_data_in,
  input  logic [NUM_SRC*DATA_BYTE_WD-1:0]   s_keep_in,
  input  logic [NUM_SRC-1:0]                s_last_in,
  output logic [NUM_SRC-1:0]                s_ready_in,
  output logic                              valid_insert,
  output logic [DATA_WD-1:0]                data_insert,
  output logic [DATA_BYTE_WD-1:0]           keep_insert,
  output logic [BYTE_CNT_WD-1:0]            byte_insert_cnt,
  input  logic                              ready_insert,
  output logic                              valid_in,
  output logic [DATA_WD-1:0]                data_in,
  output logic [DATA_BYTE_WD-1:0]           keep_in,
  output logic                              last_in,
  input  logic                              ready_in,
  output logic [SRC_ID_WD-1:0]              grant_id,
  output logic                              busy
);

  state_t                state_q, state_d;
  logic [SRC_ID_WD-1:0]  grant_id_q, grant_id_d;
  logic [NUM_SRC-1:0]    grant_oh_q, grant_oh_d;
  logic [SRC_ID_WD-1:0]  ptr_q, ptr_d;
  logic [NUM_SRC-1:0]    arb_grant;
  logic [SRC_ID_WD-1:0]  arb_idx;
  logic                  arb_any;

  logic [DATA_WD-1:0]      hdr_dat  [NUM_SRC];
  logic [DATA_BYTE_WD-1:0] hdr_keep [NUM_SRC];
  logic [DATA_WD-1:0]      pay_dat  [NUM_SRC];
  logic [DATA_BYTE_WD-1:0] pay_keep [NUM_SRC];

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_unpack
    assign hdr_dat[g]  = s_data_insert[g*DATA_WD +: DATA_WD];
    assign hdr_keep[g] = s_keep_insert[g*DATA_BYTE_WD +: DATA_BYTE_WD];
    assign pay_dat[g]  = s_data_in[g*DATA_WD +: DATA_WD];
    assign pay_keep[g] = s_keep_in[g*DATA_BYTE_WD +: DATA_BYTE_WD];
  end

  rr_arbiter #(
    .NUM_SRC   (NUM_SRC),
    .SRC_ID_WD (SRC_ID_WD)
  ) u_rr_arbiter (
    .req       (s_valid_insert),
    .ptr       (ptr_q),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .any_req   (arb_any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      grant_id_q <= '0;
      grant_oh_q <= '0;
      ptr_q      <= '0;
    end else begin
      state_q    <= state_d;
      grant_id_q <= grant_id_d;
      grant_oh_q <= grant_oh_d;
      ptr_q      <= ptr_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    grant_id_d     = grant_id_q;
    grant_oh_d     = grant_oh_q;
    ptr_d          = ptr_q;
    valid_insert   = 1'b0;
    data_insert    = '0;
    keep_insert    = '0;
    valid_in       = 1'b0;
    data_in        = '0;
    keep_in        = '0;
    last_in        = 1'b0;
    s_ready_insert = '0;
    s_ready_in     = '0;
    case (state_q)
      IDLE: begin
        if (arb_any) begin
          state_d    = HDR;
          grant_id_d = arb_idx;
          grant_oh_d = arb_grant;
        end
      end
      HDR: begin
        valid_insert   = s_valid_insert[grant_id_q];
        data_insert    = hdr_dat[grant_id_q];
        keep_insert    = hdr_keep[grant_id_q];
        s_ready_insert = grant_oh_q & {NUM_SRC{ready_insert}};
        if (valid_insert && ready_insert) begin
          state_d = PAYLOAD;
        end
      end
      PAYLOAD: begin
        valid_in   = s_valid_in[grant_id_q];
        data_in    = pay_dat[grant_id_q];
        keep_in    = pay_keep[grant_id_q];
        last_in    = s_last_in[grant_id_q];
        s_ready_in = grant_oh_q & {NUM_SRC{ready_in}};
        if (valid_in && ready_in && last_in) begin
          state_d = IDLE;
          // the finishing owner drops to lowest priority for the next round
          ptr_d   = (grant_id_q == SRC_ID_WD'(NUM_SRC-1)) ? '0 : grant_id_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    byte_insert_cnt = '0;
    for (int b = 0; b < DATA_BYTE_WD; b++) begin
      byte_insert_cnt = byte_insert_cnt + BYTE_CNT_WD'(keep_insert[b]);
    end
  end

  assign grant_id = grant_id_q;
  assign busy     = (state_q == HDR) || (state_q == PAYLOAD);

endmodule
